// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Direct-mapped data-cache controller. Holds the tag, valid,
//            dirty and data arrays. Feeds an external tag comparator and
//            uses its hit result. Serves hits with no stall. On a miss it
//            writes back a dirty victim block, then fetches the new block.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int TAG_W    = 3,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        read,
    input  logic                        write,
    input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] address,
    input  logic [7:0]                  writedata,
    output logic [7:0]                  readdata,
    output logic                        busywait,
    output logic [TAG_W-1:0]            cache_tag,
    output logic [TAG_W-1:0]            address_tag,
    output logic                        valid_bit,
    input  logic                        hit,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [TAG_W+INDEX_W-1:0]    mem_address,
    output logic [31:0]                 mem_writedata,
    input  logic [31:0]                 mem_readdata,
    input  logic                        mem_busywait
);

    localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
    localparam int NUM_BLOCKS = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE_BACK = 2'd1,
        ST_MEM_READ   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_BLOCKS-1:0]   valid_q, valid_d;
    logic [NUM_BLOCKS-1:0]   dirty_q, dirty_d;
    logic [7:0]              readdata_q, readdata_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [TAG_W+INDEX_W-1:0] mem_address_q, mem_address_d;
    logic [31:0]             mem_writedata_q, mem_writedata_d;

    logic [TAG_W-1:0]        tag_mem  [NUM_BLOCKS];
    logic [31:0]             data_mem [NUM_BLOCKS];

    logic [INDEX_W-1:0]      idx;
    logic [OFFSET_W-1:0]     offset;
    logic [TAG_W-1:0]        addr_tag;
    logic [31:0]             blk;
    logic [7:0]              sel_byte;
    logic                    is_wr;
    logic                    is_rd;
    logic                    req;
    logic                    data_we;
    logic                    tag_we;
    logic [31:0]             data_wdata;

    assign idx      = address[OFFSET_W +: INDEX_W];
    assign offset   = address[OFFSET_W-1:0];
    assign addr_tag = address[ADDR_W-1 -: TAG_W];
    assign blk      = data_mem[idx];

    // A simultaneous read and write is resolved as a write
    assign is_wr = write;
    assign is_rd = read & ~write;
    assign req   = read | write;

    // Comparator feed straight from the indexed entry
    assign cache_tag   = tag_mem[idx];
    assign valid_bit   = valid_q[idx];
    assign address_tag = addr_tag;

    // Byte lane select: offset 0 is the least significant byte
    always_comb begin
        sel_byte = blk[7:0];
        case (offset)
            2'd0:    sel_byte = blk[7:0];
            2'd1:    sel_byte = blk[15:8];
            2'd2:    sel_byte = blk[23:16];
            default: sel_byte = blk[31:24];
        endcase
    end

    // Read hits return data in the same cycle; otherwise hold the last byte
    assign readdata = (state_q == ST_IDLE && is_rd && hit) ? sel_byte : readdata_q;

    // Stall on any miss and throughout the memory sequence
    assign busywait = reset & ((state_q != ST_IDLE) | (req & ~hit));

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

    // Next-state, array-update and memory-request decode
    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        readdata_d      = readdata_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        data_we         = 1'b0;
        tag_we          = 1'b0;
        data_wdata      = blk;

        case (state_q)
            ST_IDLE: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (req && hit) begin
                    if (is_wr) begin
                        data_we = 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            if (offset == OFFSET_W'(i))
                                data_wdata[i*8 +: 8] = writedata;
                        end
                        dirty_d[idx] = 1'b1;
                    end else begin
                        readdata_d = sel_byte;
                    end
                end else if (req) begin
                    if (dirty_q[idx]) begin
                        state_d         = ST_WRITE_BACK;
                        mem_write_d     = 1'b1;
                        mem_address_d   = {tag_mem[idx], idx};
                        mem_writedata_d = blk;
                    end else begin
                        state_d       = ST_MEM_READ;
                        mem_read_d    = 1'b1;
                        mem_address_d = {addr_tag, idx};
                    end
                end
            end
            ST_WRITE_BACK: begin
                if (!mem_busywait) begin
                    state_d       = ST_MEM_READ;
                    mem_write_d   = 1'b0;
                    mem_read_d    = 1'b1;
                    mem_address_d = {addr_tag, idx};
                end
            end
            ST_MEM_READ: begin
                if (!mem_busywait) begin
                    state_d      = ST_IDLE;
                    mem_read_d   = 1'b0;
                    data_we      = 1'b1;
                    data_wdata   = mem_readdata;
                    tag_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // Controller state; reset aborts any in-flight memory sequence
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            valid_q         <= '0;
            dirty_q         <= '0;
            readdata_q      <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
            readdata_q      <= readdata_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    // Tag and data storage; not cleared, and frozen while reset is held
    always_ff @(posedge clock) begin
        if (reset && data_we)
            data_mem[idx] <= data_wdata;
        if (reset && tag_we)
            tag_mem[idx] <= addr_tag;
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Directed test of dcache_ctrl. The bench provides a tag
//            comparator and a block memory that stays busy for 5 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic [2:0]  cache_tag;
    logic [2:0]  address_tag;
    logic        valid_bit;
    logic        hit;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem [64];
    int unsigned mcnt;

    dcache_ctrl #(.TAG_W(3), .INDEX_W(3), .OFFSET_W(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .cache_tag     (cache_tag),
        .address_tag   (address_tag),
        .valid_bit     (valid_bit),
        .hit           (hit),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Tag comparator
    assign hit = valid_bit && (cache_tag == address_tag);

    // Block memory: busy for 5 cycles of each request, then completes
    assign mem_busywait = (mem_read | mem_write) && (mcnt < 5);
    assign mem_readdata = mem[mem_address];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcnt <= 0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h44332211;
            mem[8] <= 32'h88776655;
            mem[7] <= 32'hDDCCBBAA;
        end else if (mem_read | mem_write) begin
            if (!mem_busywait) begin
                mcnt <= 0;
                if (mem_write) mem[mem_address] <= mem_writedata;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step to negedges until busywait drops, bounded
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            #2;
            if (!busywait) break;
        end
        chk(tag, {31'b0, busywait}, 32'h0);
    endtask

    initial begin
        reset     = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = 8'h00;
        writedata = 8'h00;

        // Reset state
        repeat (2) @(negedge clock);
        #2;
        chk("rst_readdata",      {24'b0, readdata}, 32'h0);
        chk("rst_busywait",      {31'b0, busywait}, 32'h0);
        chk("rst_mem_read",      {31'b0, mem_read}, 32'h0);
        chk("rst_mem_write",     {31'b0, mem_write}, 32'h0);
        chk("rst_mem_address",   {26'b0, mem_address}, 32'h0);
        chk("rst_mem_writedata", mem_writedata, 32'h0);
        chk("rst_valid_bit",     {31'b0, valid_bit}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Read 0x00: cold miss, fetch block 0x00
        @(negedge clock);
        read = 1'b1; address = 8'h00;
        #2;
        chk("rd00_busy",    {31'b0, busywait}, 32'h1);
        chk("rd00_idle_mr", {31'b0, mem_read}, 32'h0);
        @(negedge clock); #2;
        chk("rd00_mem_read",  {31'b0, mem_read}, 32'h1);
        chk("rd00_mem_write", {31'b0, mem_write}, 32'h0);
        chk("rd00_mem_addr",  {26'b0, mem_address}, 32'h00);
        wait_idle("rd00_wait");
        chk("rd00_readdata", {24'b0, readdata}, 32'h11);
        chk("rd00_valid",    {31'b0, valid_bit}, 32'h1);
        chk("rd00_tag",      {29'b0, cache_tag}, 32'h0);
        chk("rd00_mr_done",  {31'b0, mem_read}, 32'h0);

        // Read 0x03: hit, upper byte lane
        @(negedge clock);
        address = 8'h03;
        #2;
        chk("rd03_readdata", {24'b0, readdata}, 32'h44);
        chk("rd03_busy",     {31'b0, busywait}, 32'h0);
        chk("rd03_mem_read", {31'b0, mem_read}, 32'h0);

        // Write 0x5A to 0x01: hit, no stall
        @(negedge clock);
        read = 1'b0; write = 1'b1; address = 8'h01; writedata = 8'h5A;
        #2;
        chk("wr01_busy", {31'b0, busywait}, 32'h0);
        @(negedge clock);
        write = 1'b0; read = 1'b1; address = 8'h01;
        #2;
        chk("rd01_readdata", {24'b0, readdata}, 32'h5A);
        chk("rd01_busy",     {31'b0, busywait}, 32'h0);

        // Write 0x77 to 0x20: dirty conflict -> write-back, fetch, write
        @(negedge clock);
        read = 1'b0; write = 1'b1; address = 8'h20; writedata = 8'h77;
        #2;
        chk("wr20_busy", {31'b0, busywait}, 32'h1);
        @(negedge clock); #2;
        chk("wb_mem_write", {31'b0, mem_write}, 32'h1);
        chk("wb_mem_read",  {31'b0, mem_read}, 32'h0);
        chk("wb_mem_addr",  {26'b0, mem_address}, 32'h00);
        chk("wb_mem_wdata", mem_writedata, 32'h44335A11);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            #2;
            if (mem_read) break;
        end
        chk("wr20_mem_read",  {31'b0, mem_read}, 32'h1);
        chk("wr20_mem_write", {31'b0, mem_write}, 32'h0);
        chk("wr20_mem_addr",  {26'b0, mem_address}, 32'h08);
        wait_idle("wr20_wait");
        @(negedge clock);
        write = 1'b0; read = 1'b1; address = 8'h20;
        #2;
        chk("rd20_readdata", {24'b0, readdata}, 32'h77);
        chk("rd20_busy",     {31'b0, busywait}, 32'h0);
        address = 8'h21;
        #2;
        chk("rd21_readdata", {24'b0, readdata}, 32'h66);
        chk("wb_mem_block0", mem[0], 32'h44335A11);

        // Read 0x00: block 0 now holds dirty tag 1 -> write-back first
        @(negedge clock);
        address = 8'h00;
        #2;
        chk("rd00b_busy", {31'b0, busywait}, 32'h1);
        @(negedge clock); #2;
        chk("rd00b_mem_write", {31'b0, mem_write}, 32'h1);
        chk("rd00b_mem_addr",  {26'b0, mem_address}, 32'h08);
        chk("rd00b_mem_wdata", mem_writedata, 32'h88776677);
        wait_idle("rd00b_wait");
        chk("rd00b_readdata", {24'b0, readdata}, 32'h11);

        // Read 0x1C: invalid index 7 -> straight to fetch
        @(negedge clock);
        address = 8'h1C;
        #2;
        chk("rd1c_busy", {31'b0, busywait}, 32'h1);
        @(negedge clock); #2;
        chk("rd1c_mem_read",  {31'b0, mem_read}, 32'h1);
        chk("rd1c_mem_write", {31'b0, mem_write}, 32'h0);
        chk("rd1c_mem_addr",  {26'b0, mem_address}, 32'h07);
        wait_idle("rd1c_wait");
        chk("rd1c_readdata", {24'b0, readdata}, 32'hAA);

        // Reset in the middle of a fetch
        @(negedge clock);
        address = 8'h04;
        @(negedge clock); #2;
        chk("rd04_mem_read", {31'b0, mem_read}, 32'h1);
        @(negedge clock);
        #3;
        reset = 1'b0; read = 1'b0;
        #1;
        chk("arst_mem_read",  {31'b0, mem_read}, 32'h0);
        chk("arst_mem_write", {31'b0, mem_write}, 32'h0);
        chk("arst_busy",      {31'b0, busywait}, 32'h0);
        chk("arst_readdata",  {24'b0, readdata}, 32'h0);
        chk("arst_valid_1",   {31'b0, valid_bit}, 32'h0);
        address = 8'h00;
        #1;
        chk("arst_valid_0",   {31'b0, valid_bit}, 32'h0);
        address = 8'h1C;
        #1;
        chk("arst_valid_7",   {31'b0, valid_bit}, 32'h0);
        @(negedge clock);
        reset = 1'b1; read = 1'b1; address = 8'h00;
        #2;
        chk("rerd00_busy", {31'b0, busywait}, 32'h1);
        wait_idle("rerd00_wait");
        chk("rerd00_readdata", {24'b0, readdata}, 32'h11);

        @(negedge clock);
        read = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped data-cache controller between the CPU and data memory: 8 blocks of 4 bytes, 8-bit byte address.
- Holds the tag, valid, dirty and data arrays, and presents the indexed tag and valid bit to the tag comparator.
- Consumes the comparator's `hit`.
- On a miss, runs the write-back and fetch sequence against a 32-bit block memory and stalls the CPU with `busywait`.

Parameters:
- TAG_W, 3, tag width; address = {tag, index, offset}.
- INDEX_W, 3, index width; 2**INDEX_W blocks.
- OFFSET_W, 2, byte offset within a block; fixed at 2 (4-byte block).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- read  input  1  CPU read request.
- write  input  1  CPU write request.
- address  input  8  CPU byte address {tag[7:5], index[4:2], offset[1:0]}.
- writedata  input  8  CPU store byte.
- readdata  output  8  CPU load byte.
- busywait  output  1  CPU stall.
- cache_tag  output  TAG_W  stored tag of the indexed block, to comparator.
- address_tag  output  TAG_W  address[7:5], to comparator.
- valid_bit  output  1  valid bit of the indexed block, to comparator.
- hit  input  1  comparator result; settles under 1 ns after its inputs change.
- mem_read  output  1  block read request.
- mem_write  output  1  block write request.
- mem_address  output  6  block address {tag, index}.
- mem_writedata  output  32  write-back block.
- mem_readdata  input  32  fetched block.
- mem_busywait  input  1  memory busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - All valid and dirty bits cleared; state=IDLE.
  - readdata=0; busywait=0; mem_read=0; mem_write=0; mem_address=0; mem_writedata=0.
  - Tag and data arrays need not be cleared.
  - Reset during WRITE_BACK or MEM_READ aborts the sequence: mem_read/mem_write drop immediately, and the in-flight block is not updated.
- Comparator outputs are combinational from the indexed entry: cache_tag=tag[index], valid_bit=valid[index], address_tag=address[7:5].
- Block byte lanes: offset 00 -> [7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24].
- Requests:
  - read and write are never both high. If they are, the request is treated as a write.
  - The CPU holds read, write, address and writedata stable while busywait=1.
- State IDLE:
  - No request: busywait=0.
  - Read hit: readdata=selected byte (combinational); busywait=0; zero stall cycles.
  - Write hit: busywait=0; at the next posedge, writedata goes into the selected byte and dirty[index]=1.
  - Miss (request high, hit=0): busywait=1 combinationally in the same cycle. At the posedge:
    - dirty[index]=1 -> WRITE_BACK.
    - otherwise (clean or invalid) -> MEM_READ.
- State WRITE_BACK:
  - busywait=1; mem_write=1; mem_address={tag[index], index}; mem_writedata=data[index].
  - On a posedge with mem_busywait=0 -> MEM_READ. mem_write deasserts in the same edge.
- State MEM_READ:
  - busywait=1; mem_read=1; mem_address={address[7:5], index}.
  - On a posedge with mem_busywait=0: data[index]=mem_readdata, tag[index]=address[7:5], valid=1, dirty=0 -> IDLE.
  - On returning to IDLE, the request re-evaluates as a hit and completes with the IDLE hit rules (one extra cycle).
- Output rules:
  - mem_read and mem_write are never both 1.
  - Both are 0 in IDLE.
  - readdata holds its last value when not reading a hit.
- Request dropped during a miss: the sequence still completes and updates the block. This is not an error.

Test Plan:
- Reset, then read addr 0x00 -> miss:
  - busywait=1; MEM_READ with mem_address=0x00.
  - Memory returns 0x44332211 after 5 busy cycles -> valid[0]=1, tag[0]=0.
  - Next cycle readdata=0x11, busywait=0.
- After the previous case, read 0x03 -> hit: readdata=0x44, busywait=0, no mem_read.
- Write 0x5A to 0x01 (hit):
  - Next cycle dirty[0]=1, byte lane [15:8]=0x5A, busywait never high.
  - Read 0x01 returns 0x5A.
- Write 0x77 to 0x20 (tag 1, index 0) with block 0 dirty:
  - WRITE_BACK: mem_address=0x00, mem_writedata=0x44335A11.
  - Then MEM_READ: mem_address=0x08.
  - Then the byte is written and dirty[0]=1.
- Read 0x1C (index 7, invalid): goes directly to MEM_READ with mem_address=0x07; no write-back.
- Assert reset low mid-MEM_READ:
  - mem_read=0 immediately; state IDLE; valid bits all 0.
  - A re-read of 0x00 misses again.
